// File: rtl/weight_loader_pkg.sv
// Shared widths, bank encodings, write payload and FSM states for the weight loader.
package weight_loader_pkg;

   localparam int unsigned WORD_W        = 10;
   localparam int unsigned WORDS_PER_ROW = 9;
   localparam int unsigned ROW_W         = WORD_W * WORDS_PER_ROW;
   localparam int unsigned NUM_BANKS     = 3;
   localparam int unsigned DEPTH         = 32;
   localparam int unsigned ADDR_W        = $clog2(DEPTH);
   localparam int unsigned COUNT_W       = ADDR_W + 1;
   localparam int unsigned WCNT_W        = 4;
   localparam int unsigned BANK_IDX_W    = 2;

   localparam logic [NUM_BANKS-1:0] BANK0 = 3'b001;
   localparam logic [NUM_BANKS-1:0] BANK1 = 3'b010;
   localparam logic [NUM_BANKS-1:0] BANK2 = 3'b100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      FINISH = 2'd2
   } state_t;

   typedef struct packed {
      logic [NUM_BANKS-1:0] bank;
      logic [ADDR_W-1:0]    addr;
      logic [ROW_W-1:0]     data;
   } wr_req_t;

   // Bank index (0..2) to one-hot bank select.
   function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_IDX_W-1:0] idx);
      case (idx)
         2'd0:    bank_onehot = BANK0;
         2'd1:    bank_onehot = BANK1;
         2'd2:    bank_onehot = BANK2;
         default: bank_onehot = '0;
      endcase
   endfunction

endpackage

// File: rtl/weight_loader_row_packer.sv
// Packs consecutive weight words into one bank row, first word at the LSBs.
module weight_loader_row_packer
   import weight_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              en,
   input  logic [WORD_W-1:0] data,
   output logic              row_complete_c,
   output logic [ROW_W-1:0]  row_c
);

   logic [WCNT_W-1:0] cnt;
   logic [ROW_W-1:0]  row;

   // Current row with the incoming word merged into its slot, so a completed row is available in the accept cycle.
   always_comb begin
      row_c = row;
      for (int unsigned k = 0; k < WORDS_PER_ROW; k++) begin
         if (cnt == WCNT_W'(k)) begin
            row_c[k*WORD_W +: WORD_W] = data;
         end
      end
   end

   assign row_complete_c = en && (cnt == WCNT_W'(WORDS_PER_ROW - 1));

   // Word counter and packing register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         row <= '0;
      end else if (clear) begin
         cnt <= '0;
         row <= '0;
      end else if (en) begin
         row <= row_c;
         cnt <= row_complete_c ? '0 : cnt + WCNT_W'(1);
      end
   end

endmodule

// File: rtl/weight_loader.sv
// Assembles a stream of weight words into rows and strobes them into bank0/1/2 per entry.
module weight_loader
   import weight_loader_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [ADDR_W-1:0]    i_base_addr,
   input  logic [COUNT_W-1:0]   i_num_entries,
   input  logic                 i_abort,
   input  logic [WORD_W-1:0]    i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_wr_en,
   output logic [NUM_BANKS-1:0] o_wr_bank,
   output logic [ADDR_W-1:0]    o_wr_addr,
   output logic [ROW_W-1:0]     o_wr_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err
);

   state_t                state, state_next;
   logic [ADDR_W-1:0]     base;
   logic [ADDR_W-1:0]     last_entry;
   logic [ADDR_W-1:0]     entry;
   logic [BANK_IDX_W-1:0] bank_idx;
   logic                  accept_c;
   logic                  row_done_c;
   logic                  last_row_c;
   logic                  start_c;
   logic                  done_next;
   logic                  err_next;
   logic [ROW_W-1:0]      row_c;
   wr_req_t               wr_req_c;

   // Abort beats a same-cycle accept, so the word is dropped.
   assign accept_c   = i_valid && (state == LOAD) && !i_abort;
   assign start_c    = i_start && (state == IDLE);
   assign last_row_c = row_done_c && (bank_idx == BANK_IDX_W'(NUM_BANKS - 1)) && (entry == last_entry);

   weight_loader_row_packer u_packer (
      .clk            (i_clk),
      .rst_n          (i_rst_n),
      .clear          (state == IDLE),
      .en             (accept_c),
      .data           (i_data),
      .row_complete_c (row_done_c),
      .row_c          (row_c)
   );

   assign wr_req_c = '{bank: bank_onehot(bank_idx), addr: base + entry, data: row_c};

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state and pulse decode.
   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      err_next   = i_start && (state != IDLE);
      case (state)
         IDLE: begin
            if (i_start) state_next = LOAD;
         end
         LOAD: begin
            if (i_abort)         state_next = IDLE;
            else if (last_row_c) state_next = FINISH;
         end
         FINISH: begin
            state_next = IDLE;
            done_next  = !i_abort;
         end
         default: state_next = IDLE;
      endcase
   end

   // Load parameters plus bank/entry position; 0 entries wraps to a full 32-entry load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         base       <= '0;
         last_entry <= '0;
         entry      <= '0;
         bank_idx   <= '0;
      end else if (start_c) begin
         base       <= i_base_addr;
         last_entry <= ADDR_W'(i_num_entries - COUNT_W'(1));
         entry      <= '0;
         bank_idx   <= '0;
      end else if (row_done_c) begin
         if (bank_idx == BANK_IDX_W'(NUM_BANKS - 1)) begin
            bank_idx <= '0;
            entry    <= entry + ADDR_W'(1);
         end else begin
            bank_idx <= bank_idx + BANK_IDX_W'(1);
         end
      end
   end

   // Registered outputs; write payload updates only when a row completes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ready   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         o_wr_en   <= 1'b0;
         o_wr_bank <= '0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
      end else begin
         o_ready <= (state_next == LOAD);
         o_busy  <= (state_next != IDLE);
         o_done  <= done_next;
         o_err   <= err_next;
         o_wr_en <= row_done_c;
         if (row_done_c) begin
            o_wr_bank <= wr_req_c.bank;
            o_wr_addr <= wr_req_c.addr;
            o_wr_data <= wr_req_c.data;
         end
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: directed loads with random data checked against a row model.
module tb_weight_loader;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic [4:0]  i_base_addr;
   logic [5:0]  i_num_entries;
   logic        i_abort;
   logic [9:0]  i_data;
   logic        i_valid;
   logic        o_ready;
   logic        o_wr_en;
   logic [2:0]  o_wr_bank;
   logic [4:0]  o_wr_addr;
   logic [89:0] o_wr_data;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   typedef struct packed {
      logic [2:0]  bank;
      logic [4:0]  addr;
      logic [89:0] data;
   } wr_t;

   wr_t got[$];
   time got_t[$];
   int  done_count = 0;
   int  err_count  = 0;
   time done_t     = 0;
   int  checks     = 0;
   int  errors     = 0;

   weight_loader dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_base_addr   (i_base_addr),
      .i_num_entries (i_num_entries),
      .i_abort       (i_abort),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .o_wr_en       (o_wr_en),
      .o_wr_bank     (o_wr_bank),
      .o_wr_addr     (o_wr_addr),
      .o_wr_data     (o_wr_data),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Observe outputs mid-cycle, away from the rising edge.
   always @(negedge i_clk) begin
      if (o_wr_en) begin
         got.push_back('{o_wr_bank, o_wr_addr, o_wr_data});
         got_t.push_back($time);
      end
      if (o_done) begin
         done_count++;
         done_t = $time;
      end
      if (o_err) err_count++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One load: stall_pct = chance of an idle input cycle; abort_idx/busy_cyc/rst_idx < 0 disable those events.
   task automatic run_load(input string name, input logic [4:0] base, input logic [5:0] num,
                           input int stall_pct, input int abort_idx, input int busy_cyc,
                           input int rst_idx, input bit seq, input bit chk_gap);
      logic [9:0] words[$];
      int  n, nwords, idx, cyc, n0, d0, e0, exp_rows, nchk;
      bit  stop, acc, aborted, was_reset;
      time start_t;
      n = (num == 6'd0) ? 32 : int'(num);
      nwords = 27 * n;
      for (int i = 0; i < nwords; i++) words.push_back(seq ? 10'(i + 1) : 10'($urandom));
      n0 = got.size(); d0 = done_count; e0 = err_count;
      stop = 0; aborted = 0; was_reset = 0;
      exp_rows = 3 * n;

      @(posedge i_clk); #1;
      i_start = 1'b1; i_base_addr = base; i_num_entries = num;
      start_t = $time - 1;
      @(posedge i_clk); #1;
      i_start = 1'b0;

      idx = 0; cyc = 0;
      while (idx < nwords && !stop && cyc < 5000) begin
         i_valid = (int'($urandom_range(99)) >= stall_pct);
         i_data  = words[idx];
         i_abort = (idx == abort_idx);
         if (cyc == busy_cyc) begin
            i_start = 1'b1; i_base_addr = base + 5'd3; i_num_entries = 6'd2;
         end
         acc = i_valid && o_ready && !i_abort;
         @(posedge i_clk); #1;
         if (i_abort) begin
            stop = 1; aborted = 1;
            exp_rows = abort_idx / 9;
         end
         i_start = 1'b0; i_abort = 1'b0; i_base_addr = base; i_num_entries = num;
         if (acc) idx++;
         if (acc && idx == rst_idx) begin
            chk({name, " inflight_wr_en"}, 128'(o_wr_en), 128'(1));
            i_rst_n = 1'b0;
            #1;
            chk({name, " rst_wr_en"}, 128'(o_wr_en), 128'(0));
            chk({name, " rst_busy"}, 128'(o_busy), 128'(0));
            stop = 1; was_reset = 1;
            exp_rows = (rst_idx - 1) / 9;
         end
         cyc++;
      end
      i_valid = 1'b0;
      if (!stop) chk({name, " words_accepted_in_budget"}, 128'(idx), 128'(nwords));

      if (aborted) begin
         chk({name, " busy_after_abort"}, 128'(o_busy), 128'(0));
         repeat (40) @(negedge i_clk);
         chk({name, " no_done"}, 128'(done_count - d0), 128'(0));
      end else if (was_reset) begin
         repeat (3) @(posedge i_clk);
         #1 i_rst_n = 1'b1;
         repeat (40) @(negedge i_clk);
         chk({name, " no_done"}, 128'(done_count - d0), 128'(0));
      end else begin
         for (int w = 0; w < 10 && done_count == d0; w++) @(negedge i_clk);
         chk({name, " done_count"}, 128'(done_count - d0), 128'(1));
         if (stall_pct == 0)
            chk({name, " done_latency"}, 128'((done_t - 5 - start_t) / 10), 128'(27 * n + 2));
         repeat (5) @(negedge i_clk);
         chk({name, " busy_after_done"}, 128'(o_busy), 128'(0));
      end

      chk({name, " write_count"}, 128'(got.size() - n0), 128'(exp_rows));
      chk({name, " err_pulses"}, 128'(err_count - e0), 128'((busy_cyc >= 0) ? 1 : 0));
      nchk = (got.size() - n0 < exp_rows) ? got.size() - n0 : exp_rows;
      for (int r = 0; r < nchk; r++) begin
         wr_t e;
         e.data = '0;
         for (int k = 0; k < 9; k++) e.data[10*k +: 10] = words[9*r + k];
         e.bank = 3'(1 << (r % 3));
         e.addr = 5'((int'(base) + r / 3) % 32);
         chk($sformatf("%s row%0d", name, r), 128'(got[n0 + r]), 128'(e));
      end
      if (chk_gap && got.size() - n0 >= 3) begin
         chk({name, " gap01"}, 128'(got_t[n0 + 1] - got_t[n0]), 128'(90));
         chk({name, " gap12"}, 128'(got_t[n0 + 2] - got_t[n0 + 1]), 128'(90));
         chk({name, " first_word_lsb"}, 128'(got[n0].data[9:0]), 128'(1));
         chk({name, " ninth_word_msb"}, 128'(got[n0].data[89:80]), 128'(9));
      end
   endtask

   initial begin
      i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_num_entries = '0;
      i_abort = 1'b0; i_data = '0; i_valid = 1'b0;
      #12;
      chk("reset_outputs", 128'({o_ready, o_wr_en, o_wr_bank, o_wr_addr, o_busy, o_done, o_err}), 128'(0));
      chk("reset_wr_data", 128'(o_wr_data), 128'(0));
      #10 i_rst_n = 1'b1;

      // Words presented while idle must not be taken.
      i_valid = 1'b1; i_data = 10'h3ff;
      repeat (5) @(negedge i_clk);
      chk("idle_ready", 128'(o_ready), 128'(0));
      chk("idle_no_write", 128'(got.size()), 128'(0));
      i_valid = 1'b0;

      run_load("single",   5'd0,  6'd1, 0,  -1, -1, -1,            1'b1, 1'b1);
      run_load("wrap",     5'd31, 6'd2, 0,  -1, -1, -1,            1'b0, 1'b0);
      run_load("stall",    5'd10, 6'd3, 40, -1, -1, -1,            1'b0, 1'b0);
      run_load("abort",    5'd2,  6'd2, 0,  13, -1, -1,            1'b0, 1'b0);
      run_load("busy",     5'd4,  6'd1, 0,  -1, 4,  -1,            1'b0, 1'b0);
      run_load("full",     5'd7,  6'd0, 0,  -1, -1, -1,            1'b0, 1'b0);
      run_load("rst_mid",  5'd0,  6'd0, 0,  -1, -1, 27 * 5 + 9,    1'b0, 1'b0);
      run_load("post_rst", 5'd20, 6'd1, 20, -1, -1, -1,            1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
Write-side counterpart of the weight ROM. Accepts a valid/ready stream of 10-bit weight words from the host/DMA path and assembles them into 90-bit rows (9 words). It issues one-cycle write strobes into the three weight banks (bank0/1/2, 32 entries each), indexed by opcode address, so that weights are loadable at run time instead of fixed at elaboration.

Parameters:
WORD_W, 10, width of one weight word
WORDS_PER_ROW, 9, words packed per 90-bit bank row
ROW_W, 90, bank row width (WORD_W*WORDS_PER_ROW)
NUM_BANKS, 3, banks written per entry (bank0, bank1, bank2 in order)
DEPTH, 32, entries per bank
ADDR_W, 5, entry address width

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  one-cycle load request, sampled only in IDLE
i_base_addr  in  5  first entry address
i_num_entries  in  6  entries to load, 1..32; 0 means 32
i_abort  in  1  synchronous abort of the current load
i_data  in  10  weight word
i_valid  in  1  i_data valid
o_ready  out  1  word accepted when i_valid & o_ready
o_wr_en  out  1  bank write strobe, one cycle per row
o_wr_bank  out  3  one-hot bank select (001=bank0, 010=bank1, 100=bank2)
o_wr_addr  out  5  entry address
o_wr_data  out  90  row data
o_busy  out  1  high when state != IDLE
o_done  out  1  one-cycle pulse at completion of a load
o_err  out  1  one-cycle pulse when i_start arrives while busy

Behaviour:
- Reset: state IDLE; all outputs 0; word, bank, and entry counters 0; the packing register is cleared.
- Every output is registered. o_ready = (state==LOAD), taken from the state register.
- IDLE: i_start latches base and count (0 maps to 32), clears the counters, and moves to LOAD next cycle.
- LOAD: on each accept, the word at word index k (0..8) goes to bits [10k+9:10k] of the row, so the first word is at the LSBs.
- LOAD, ninth word: on accepting word index 8, the next cycle has o_wr_en=1, o_wr_data = the completed row, o_wr_bank = the current bank, and o_wr_addr = (base + entry) mod 32. The address wraps, with no carry into a sixth bit.
- LOAD, counters after the ninth word: the word counter resets to 0 and the bank advances 0→1→2. After bank2, the bank returns to 0 and the entry increments.
- LOAD, throughput: o_ready stays high while rows are written, giving 1 word per cycle with no bubble.
- LOAD, idle input: when i_valid=0, the counters hold.
- Final word: accepting the last word of the last entry (bank2, word 8) moves the state to FINISH. In FINISH, o_ready=0 and o_wr_en=1 for the final row. The next cycle has o_done=1 and the state returns to IDLE.
- Latency: for N entries with no stalls, o_done comes 27·N + 2 cycles after the start cycle.
- i_abort in LOAD or FINISH: the state goes to IDLE next cycle. A partial row is discarded and never written, o_done is not pulsed, and rows already written remain.
- i_abort and an accept in the same cycle: abort wins. That word is dropped and triggers no write.
- i_start while busy: it is ignored, the load continues unchanged, and o_err pulses for 1 cycle.
- Asynchronous reset mid-load: takes effect immediately. Any in-flight o_wr_en is cleared, and no write or done is issued.
- Words presented in IDLE are not accepted (o_ready=0).

Decomposition:
- Shared package: WORD_W, WORDS_PER_ROW, ROW_W, DEPTH, ADDR_W, the bank one-hot constants, and the state encoding (IDLE, LOAD, FINISH).
- Sub-module row_packer: the 4-bit word counter plus the 90-bit packing register. It outputs a row_complete pulse and the row. It has clear and enable inputs and the same clock and reset.

Test Plan:
- Single entry: base=0, num=1, words 1..27 with no stalls → three writes at addr 0.
  - Banks 001, 010, 100 on consecutive 9-cycle boundaries.
  - bank0 data has word 1 in [9:0] and word 9 in [89:80].
  - o_done arrives 29 cycles after start.
- Wrap: base=31, num=2 → writes go to addr 31 (×3 banks), then addr 0 (×3). There are no other addresses and exactly 6 strobes.
- Backpressure: i_valid toggled randomly over num=3 → data and write order are identical to the no-stall run. Counters hold during gaps, and there are 9 writes.
- Abort: i_abort at word 13 of entry 0 → only the bank0 write occurs. o_busy drops next cycle, and there is no o_done or further strobe.
- Start while busy: i_start at cycle 5 of a load → o_err pulses once and the load completes unchanged.
- num=0 plus asynchronous reset: num=0 gives 96 writes covering addresses 0..31. A second num=0 run with i_rst_n pulled low mid-load clears o_wr_en and o_busy immediately, with no o_done.
